bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//   Two-master arbiter sharing the single Avalon-style bus memory port between
//   the CPU instruction-fetch port (read-only, I) and the data port (read/write, D).
//   One master is granted per transfer with round-robin fairness. Waitrequest is
//   forwarded to the granted master only. Read responses are routed back to the
//   master that issued the read, using a pipeline that tracks read ownership.
// PARAMETERS
//   READ_LATENCY  1  cycles from read acceptance (m_read & !m_waitrequest) to m_readdata valid; legal range 1..4
// PORTS
//   clk              in   1   system clock; all state on posedge
//   reset            in   1   synchronous, active-high reset
//   i_address        in   32  I master address
//   i_read           in   1   I master read request
//   i_waitrequest    out  1   I master stall
//   i_readdata       out  32  I read data (carries m_readdata)
//   i_readdatavalid  out  1   I read data valid (1-cycle pulse)
//   d_address        in   32  D master address
//   d_byteenable     in   4   D master byte lanes
//   d_writedata      in   32  D master write data
//   d_read           in   1   D master read request
//   d_write          in   1   D master write request
//   d_waitrequest    out  1   D master stall
//   d_readdata       out  32  D read data (carries m_readdata)
//   d_readdatavalid  out  1   D read data valid (1-cycle pulse)
//   m_address        out  32  to memory
//   m_byteenable     out  4   to memory; I grant drives 4'b1111
//   m_writedata      out  32  to memory
//   m_read           out  1   to memory
//   m_write          out  1   to memory
//   m_waitrequest    in   1   from memory
//   m_readdata       in   32  from memory
// BEHAVIOUR
//   States: IDLE, GNT_I, GNT_D. Register last_gnt (I/D) for round-robin.
//   Reset: state=IDLE; last_gnt=D (I wins the first tie, so boot fetch goes first);
//     response pipeline cleared. Outputs after reset: m_read=m_write=0;
//     m_address/m_byteenable/m_writedata=0; i_/d_waitrequest=1; *_readdatavalid=0.
//   IDLE: bus outputs zero; both waitrequests 1. The registered grant decision
//     takes effect next cycle: only I requests -> GNT_I; only D requests -> GNT_D;
//     both request -> the master != last_gnt; no request -> stay in IDLE.
//   GNT_x: m_* is driven combinationally from master x. x_waitrequest=m_waitrequest.
//     The other master's waitrequest=1.
//   Acceptance occurs when (m_read|m_write) & !m_waitrequest. On acceptance:
//     last_gnt<=x, and the next state is re-arbitrated from the current cycle's
//     requests (excluding x's accepted request). This allows back-to-back
//     transfers without an IDLE bubble. If no other request is pending -> IDLE.
//   A granted master that drops its request before acceptance is a protocol
//     violation. No transfer is issued, and the arbiter returns to IDLE next cycle.
//   D asserting d_read & d_write together is illegal. The arbiter forwards the
//     write only (m_read forced 0).
//   Response pipeline: a READ_LATENCY-deep shift register of {valid, owner}.
//     It is loaded at read acceptance. When an entry exits, it pulses the owner's
//     *_readdatavalid for exactly 1 cycle. i_readdata and d_readdata are both
//     wired to m_readdata. Writes create no entry.
//   Pipelined reads from alternating masters are legal. Responses return in
//     issue order, and each response is tagged by its own owner bit.
//   Reset mid-transfer: the grant is abandoned, in-flight responses are
//     discarded (no valid pulse), and masters reissue.
// TESTING
//   1. Reset held 2 cycles, then released -> m_read=m_write=0, both waitrequest=1, no valid pulses.
//   2. I reads 0xBFC00000, memory waitrequest=0 -> m_read=1 in cycle 2; i_readdatavalid
//      pulses READ_LATENCY cycles after acceptance with the memory word; d_readdatavalid stays 0.
//   3. I and D both request from reset -> I served first, then D, then I again
//      (strict alternation over 6 transfers).
//   4. D writes 0xDEADBEEF, byteenable 4'b0011, with m_waitrequest high for 3 cycles
//      -> d_waitrequest high for 3 cycles; m_write held stable; I stalled throughout.
//   5. Back-to-back reads I@0xBFC00000, then D@0x00001000 -> reads on consecutive
//      cycles; valid pulses go I first, then D, each with its own data.
//   6. Reset asserted one cycle after a read is accepted -> no readdatavalid pulse; state IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) round-robin arbiter onto one
// Avalon-style memory port, with a read-ownership pipeline for responses.
module bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readdatavalid,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  input  logic        d_read,
  input  logic        d_write,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_gnt;          // 1: D was granted last
  logic   [READ_LATENCY-1:0] r_vld;
  logic   [READ_LATENCY-1:0] r_own; // 1: response belongs to D
  logic   w_d_req;
  logic   w_acc;
  logic   w_rd_acc;

  assign w_d_req  = d_read | d_write;
  assign w_acc    = (m_read | m_write) & ~m_waitrequest;
  assign w_rd_acc = m_read & ~m_waitrequest;

  // State register and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_last_gnt <= (r_state == GNT_D);
    end
  end

  // Next-state decision and bus muxing
  always_comb begin
    w_next        = r_state;
    m_address     = '0;
    m_byteenable  = '0;
    m_writedata   = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_read && w_d_req)
          w_next = r_last_gnt ? GNT_I : GNT_D;
        else if (i_read)
          w_next = GNT_I;
        else if (w_d_req)
          w_next = GNT_D;
        else
          w_next = IDLE;
      end
      GNT_I: begin
        m_address     = i_address;
        m_byteenable  = '1;
        m_read        = i_read;
        i_waitrequest = m_waitrequest;
        if (!i_read)
          w_next = IDLE;
        else if (!m_waitrequest)
          w_next = w_d_req ? GNT_D : IDLE;
      end
      GNT_D: begin
        m_address     = d_address;
        m_byteenable  = d_byteenable;
        m_writedata   = d_writedata;
        m_write       = d_write;
        m_read        = d_read & ~d_write;
        d_waitrequest = m_waitrequest;
        if (!w_d_req)
          w_next = IDLE;
        else if (!m_waitrequest)
          w_next = i_read ? GNT_I : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Read response ownership pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      r_own[0] <= (r_state == GNT_D);
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_own[k] <= r_own[k-1];
      end
    end
  end

  // Gated by reset so a response exiting during reset is dropped.
  assign i_readdatavalid = r_vld[READ_LATENCY-1] & ~r_own[READ_LATENCY-1] & ~reset;
  assign d_readdatavalid = r_vld[READ_LATENCY-1] &  r_own[READ_LATENCY-1] & ~reset;
  assign i_readdata      = m_readdata;
  assign d_readdata      = m_readdata;

endmodule
